// File: rtl/sprite_draw_if.sv
// Sprite ROM bus: registered address out to the ROM, RGB word back one clock later.
interface sprite_draw_if #(
  parameter int ADDR_W = 8,
  parameter int RGB_W  = 12
);
  logic [ADDR_W-1:0] rom_addr;
  logic [RGB_W-1:0]  rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/sprite_draw.sv
// Sprite compositor around a synchronous 16x16 sprite ROM: address generation,
// colour-key transparency over the background, and per-frame collision reporting.
module sprite_draw #(
  parameter int          SIZE_LOG2   = 4,
  parameter int          COORD_W     = 11,
  parameter logic [11:0] TRANSPARENT = 12'h000,
  parameter logic [11:0] BG_KEY      = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic               blank,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               mirror_x,
  input  logic [11:0]        bg_rgb,
  sprite_draw_if.master      rom,
  output logic [11:0]        rgb_out,
  output logic               collision,
  output logic               collision_pulse
);

  localparam int ADDR_W = 2 * SIZE_LOG2;
  localparam logic [COORD_W:0] EDGE = (COORD_W+1)'(1 << SIZE_LOG2);

  function automatic logic [11:0] composite(input logic blank_i, input logic hit_i,
                                            input logic [11:0] sprite_i,
                                            input logic [11:0] bg_i);
    if (blank_i)                              return 12'h000;
    else if (hit_i && sprite_i != TRANSPARENT) return sprite_i;
    else                                      return bg_i;
  endfunction

  logic [COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic               act_mirror_q, act_mirror_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               hit_p1_q, hit_p1_d, blank_p1_q, blank_p1_d;
  logic [11:0]        bg_p1_q, bg_p1_d;
  logic               hit_p2_q, hit_p2_d, blank_p2_q, blank_p2_d;
  logic [11:0]        bg_p2_q, bg_p2_d;
  logic [11:0]        rgb_out_q, rgb_out_d;
  logic               acc_q, acc_d, collision_q, collision_d, pulse_q, pulse_d;

  logic [COORD_W:0]   hx_p0, vy_p0, ax_p0, ay_p0;
  logic               hit_p0, event_p2;
  logic [SIZE_LOG2-1:0] dx_p0, dy_p0, col_p0;

  // Stage 0: hit test and ROM address, extra MSB keeps act+16 from wrapping
  always_comb begin
    act_x_d      = act_x_q;
    act_y_d      = act_y_q;
    act_mirror_d = act_mirror_q;
    if (frame_start) begin
      act_x_d      = pos_x;
      act_y_d      = pos_y;
      act_mirror_d = mirror_x;
    end

    hx_p0  = {1'b0, hcount};
    vy_p0  = {1'b0, vcount};
    ax_p0  = {1'b0, act_x_q};
    ay_p0  = {1'b0, act_y_q};
    hit_p0 = !blank && (hx_p0 >= ax_p0) && (hx_p0 < ax_p0 + EDGE)
                    && (vy_p0 >= ay_p0) && (vy_p0 < ay_p0 + EDGE);
    dx_p0  = hcount[SIZE_LOG2-1:0] - act_x_q[SIZE_LOG2-1:0];
    dy_p0  = vcount[SIZE_LOG2-1:0] - act_y_q[SIZE_LOG2-1:0];
    col_p0 = act_mirror_q ? ~dx_p0 : dx_p0;

    rom_addr_d = hit_p0 ? {dy_p0, col_p0} : '0;
    hit_p1_d   = hit_p0;
    blank_p1_d = blank;
    bg_p1_d    = bg_rgb;

    // Stage 1: ROM access cycle, side-band data just follows along
    hit_p2_d   = hit_p1_q;
    blank_p2_d = blank_p1_q;
    bg_p2_d    = bg_p1_q;

    // Stage 2: composite and collision; a coincident event opens the new frame
    rgb_out_d = composite(blank_p2_q, hit_p2_q, rom.rom_data, bg_p2_q);
    event_p2  = hit_p2_q && !blank_p2_q && (rom.rom_data != TRANSPARENT)
                && (bg_p2_q != BG_KEY);
    if (frame_start) begin
      collision_d = acc_q;
      pulse_d     = acc_q;
      acc_d       = event_p2;
    end else begin
      collision_d = collision_q;
      pulse_d     = 1'b0;
      acc_d       = acc_q | event_p2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_x_q      <= '0;
      act_y_q      <= '0;
      act_mirror_q <= 1'b0;
      rom_addr_q   <= '0;
      hit_p1_q     <= 1'b0;
      blank_p1_q   <= 1'b0;
      bg_p1_q      <= '0;
      hit_p2_q     <= 1'b0;
      blank_p2_q   <= 1'b0;
      bg_p2_q      <= '0;
      rgb_out_q    <= '0;
      acc_q        <= 1'b0;
      collision_q  <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      act_x_q      <= act_x_d;
      act_y_q      <= act_y_d;
      act_mirror_q <= act_mirror_d;
      rom_addr_q   <= rom_addr_d;
      hit_p1_q     <= hit_p1_d;
      blank_p1_q   <= blank_p1_d;
      bg_p1_q      <= bg_p1_d;
      hit_p2_q     <= hit_p2_d;
      blank_p2_q   <= blank_p2_d;
      bg_p2_q      <= bg_p2_d;
      rgb_out_q    <= rgb_out_d;
      acc_q        <= acc_d;
      collision_q  <= collision_d;
      pulse_q      <= pulse_d;
    end
  end

  assign rom.rom_addr     = rom_addr_q;
  assign rgb_out          = rgb_out_q;
  assign collision        = collision_q;
  assign collision_pulse  = pulse_q;

endmodule

// File: doc/sprite_draw.md
Name: sprite_draw

Overview:
- Pixel-pipeline stage directly upstream and downstream of the 16x16 spaceship sprite ROM.
- Converts the VGA scan position and the sprite position into a ROM address, then consumes the ROM's 12-bit RGB word one clock later.
- Composites the sprite over the background pixel with colour-key transparency, and reports a per-frame sprite/background collision flag to game logic.

Parameters:
- SIZE_LOG2, 4, log2 of sprite edge in pixels; 16x16 sprite, ROM address = {row[3:0], col[3:0]}.
- COORD_W, 11, width of scan and position coordinates.
- TRANSPARENT, 12'h000, ROM colour treated as see-through.
- BG_KEY, 12'h000, background colour that never counts as a collision.

Ports:
- clk  in  1  pixel clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hcount  in  COORD_W  current pixel column.
- vcount  in  COORD_W  current pixel row.
- blank  in  1  1 = outside visible area.
- frame_start  in  1  single-cycle pulse at the start of vertical blank.
- pos_x  in  COORD_W  requested sprite left edge.
- pos_y  in  COORD_W  requested sprite top edge.
- mirror_x  in  1  requested horizontal flip.
- bg_rgb  in  12  background pixel for the current hcount/vcount.
- rom_addr  out  8  address to sprite ROM (registered).
- rom_data  in  12  ROM output; valid one clock after rom_addr.
- rgb_out  out  12  composited pixel.
- collision  out  1  sticky result for the previous frame.
- collision_pulse  out  1  one-cycle pulse when a frame with a collision ends.

Behaviour:
- Reset (async, rst=1): act_x, act_y, act_mirror, rom_addr, rgb_out, collision, collision_pulse, accumulator and all pipeline registers = 0.
- Position latch: on a clk edge with frame_start=1, act_x<=pos_x, act_y<=pos_y, act_mirror<=mirror_x. Position is never updated mid-frame (no tearing).
- Stage 1 (edge E0):
  - hit = hcount>=act_x && hcount<act_x+16 && vcount>=act_y && vcount<act_y+16 && !blank.
  - Comparisons use COORD_W+1 bits so act_x+16 does not wrap; a sprite at 2040 clips, it does not reappear at column 0.
  - dx = hcount-act_x, dy = vcount-act_y, low 4 bits only.
  - col = act_mirror ? 15-dx : dx.
  - rom_addr <= hit ? {dy,col} : 8'h00.
  - hit, blank and bg_rgb are registered into delay stage d1.
- ROM stage (edge E1): the ROM registers rom_data; d1 shifts to d2.
- Stage 3 (edge E2):
  - rgb_out <= blank_d2 ? 12'h000 : (hit_d2 && rom_data!=TRANSPARENT) ? rom_data : bg_rgb_d2.
  - Fixed latency: rgb_out updated at E2 corresponds to inputs sampled at E0 (2 clocks). Downstream sync signals must be delayed 2 clocks externally.
- Collision detection, also at stage 3:
  - event = hit_d2 && !blank_d2 && rom_data!=TRANSPARENT && bg_rgb_d2!=BG_KEY.
  - acc <= acc | event.
- Frame rollover, on frame_start:
  - collision <= acc; collision_pulse <= acc; acc <= event (an event in the same cycle belongs to the new frame).
  - collision_pulse is 0 on every other cycle.
- Reset mid-frame: outputs drop to 0 immediately. Until the next frame_start the sprite sits at (0,0), unmirrored.
- No backpressure; one pixel per clock, always.

Test Plan:
- Reset, pos=(100,50) with frame_start pulse, scan to (102,51) non-blank -> rom_addr=8'h12 one edge later; rgb_out=12'hb2a two edges after input (ROM loaded with the spaceship image).
- Same position, hcount=100, vcount=50 (ROM word 0 = 12'h000), bg_rgb=12'h00f -> rgb_out=12'h00f (transparent passes background).
- mirror_x=1 latched, scan (100,51) -> rom_addr=8'h1f; mirror_x toggled without frame_start -> address unchanged.
- pos_x=2040, hcount=2047 -> hit; hcount=0..15 on the same row -> rom_addr=0, rgb_out=bg_rgb (no wrap); blank=1 anywhere -> rgb_out=0.
- bg_rgb=12'h0f0 under an opaque sprite pixel during the frame, then frame_start -> collision=1 and collision_pulse high exactly 1 cycle. Next frame with no overlap, then frame_start -> collision=0, no pulse. Event coincident with frame_start -> reported at the following frame_start.
- Assert rst mid-scan -> rgb_out, rom_addr, collision = 0 asynchronously. After release, sprite at (0,0) until the next frame_start.
